hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller that drives the stall/flush inputs of the PC register and the F/D, D/E and E/M pipeline registers. It handles four events:
- data-memory wait stalls;
- branch/jump redirects resolved in EX;
- load-use bubbles;
- instruction-fetch wait bubbles.

It also tracks wrong-path fetches still in flight after a redirect, runs a data-memory timeout watchdog, and optionally provides performance counters. The stall/flush outputs are combinational from the current inputs and state, and are consumed in the same cycle by the pipeline registers (stall has priority over flush there).

## Interface
- MEM_TIMEOUT, 255: consecutive dmem-stall cycles before `mem_timeout` sets; range 1..255.
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- d_valid  in  1  decode stage holds an instruction
- d_rs1, d_rs2  in  5 each  decode source registers
- d_use_rs1, d_use_rs2  in  1 each  source actually read
- e_valid  in  1  EX stage holds an instruction
- e_rd  in  5  EX destination register
- e_is_load  in  1  EX instruction is a load
- e_redirect  in  1  EX resolved a taken branch/jump (PC must reload)
- m_req  in  1  MEM stage has a dmem access outstanding
- m_ready  in  1  dmem access completes this cycle
- i_ready  in  1  imem returns the fetch for the current request this cycle
- stall_pc, stall_fd, stall_de, stall_em  out  1 each  hold respective register
- flush_fd, flush_de  out  1 each  load bubble into respective register
- mem_timeout  out  1  sticky watchdog flag
- stall_cycles  out  32  perf counter (see Configuration)
- flush_events  out  32  perf counter (see Configuration)

## Operation
Internal terms:
- dstall = m_req & ~m_ready.
- redir = e_valid & e_redirect.
- lu = d_valid & e_valid & e_is_load & (e_rd != 0) & ((d_use_rs1 & d_rs1 == e_rd) | (d_use_rs2 & d_rs2 == e_rd)).
- fwait = ~i_ready | (fstate == DISCARD).

Output priority, first match wins. All outputs not listed in a row are 0.
1. dstall: stall_pc = stall_fd = stall_de = stall_em = 1.
2. redir: flush_fd = flush_de = 1. stall_pc = 0, so the PC loads the target.
3. lu: stall_pc = stall_fd = 1, flush_de = 1 (one bubble).
4. fwait: stall_pc = 1, flush_fd = 1.
5. otherwise all outputs 0.

Fetch FSM, fstate ∈ {RUN, DISCARD}. The transitions below are evaluated only when dstall = 0; under dstall, fstate holds except for DISCARD→RUN on i_ready.
- RUN → DISCARD when redir & ~i_ready (a wrong-path fetch is in flight).
- RUN stays RUN on redir & i_ready; the returning word is killed by flush_fd.
- DISCARD → RUN when i_ready. The stale word is still flushed that cycle (fwait = 1).
- DISCARD with redir & ~i_ready: stays DISCARD.

Watchdog: 8-bit wait_cnt.
- Increments (saturating at 255) each cycle dstall = 1; clears when dstall = 0.
- mem_timeout sets when dstall & wait_cnt == MEM_TIMEOUT - 1, and stays 1 until reset.
- It is a status flag only; it does not change stall behaviour.

## Timing
- Stall/flush outputs are combinational: zero-cycle latency from inputs.
- fstate, wait_cnt, mem_timeout and the counters update on posedge clk.
- Synchronous reset (nrst = 0 at posedge):
  - fstate = RUN, wait_cnt = 0, mem_timeout = 0, stall_cycles = 0, flush_events = 0.
  - While nrst = 0, all stall_*/flush_* outputs are forced to 0.
- Load-use costs exactly 1 cycle. The next cycle the load sits in MEM, lu = 0, and forwarding covers the value.
- A redirect that coincides with dstall is deferred. EX is held, so e_redirect stays asserted and is taken on the first cycle with dstall = 0.
- Reset mid-DISCARD returns to RUN. The imem interface is reset with the core, so no stale response is expected.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cycles increments each cycle stall_pc = 1.
  - flush_events increments each cycle flush_de = 1 caused by redir.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- HAZ_PERF_CNT_EN undefined: both ports are present and tied to 32'd0, and no counter flops are built.

## Test plan
- Load-use: e_valid = 1, e_is_load = 1, e_rd = 5; d_valid = 1, d_rs2 = 5, d_use_rs2 = 1, i_ready = 1 → exactly one cycle of stall_pc = stall_fd = flush_de = 1. With e_rd = 0 → no stall.
- Dmem wait: m_req = 1, m_ready = 0 for 3 cycles, then m_ready = 1 → all four stalls high for 3 cycles, low on the 4th. Apply e_redirect = 1 throughout: flush_fd/flush_de assert only in the 4th cycle.
- Wrong-path discard: redirect with i_ready = 0 → fstate = DISCARD. Next cycle with i_ready = 1 → flush_fd = 1, stall_pc = 1; the following cycle with i_ready = 1 → no flush, fstate = RUN.
- Watchdog: MEM_TIMEOUT = 4, dstall held 4 cycles → mem_timeout rises after the 4th posedge and stays 1 after dstall drops; nrst = 0 for one cycle clears it.
- Perf counters (macro on): 10 stall_pc cycles and 2 redirects → stall_cycles = 10, flush_events = 2. Preload near wrap → 0xFFFFFFFF + 1 = 0. Macro off → both read 0.
- Priority: dstall, redir and lu all high in one cycle → only the four stalls asserted, no flushes.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. Produces stall/flush controls for the
//            PC, F/D, D/E and E/M registers from dmem waits, EX redirects,
//            load-use dependencies and imem fetch waits. Tracks wrong-path
//            fetches after a redirect and runs a dmem-wait watchdog.
// Options  : HAZ_PERF_CNT_EN - builds the stall_cycles / flush_events counters;
//            when undefined both ports read constant zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        d_valid,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic        d_use_rs1,
    input  logic        d_use_rs2,
    input  logic        e_valid,
    input  logic [4:0]  e_rd,
    input  logic        e_is_load,
    input  logic        e_redirect,
    input  logic        m_req,
    input  logic        m_ready,
    input  logic        i_ready,
    output logic        stall_pc,
    output logic        stall_fd,
    output logic        stall_de,
    output logic        stall_em,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam logic [7:0] C_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        FS_RUN     = 1'b0,
        FS_DISCARD = 1'b1
    } fstate_t;

    fstate_t    r_fstate;
    fstate_t    w_fstate_nxt;
    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;

    logic w_dstall;
    logic w_redir;
    logic w_lu;
    logic w_fwait;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_dstall  = m_req & ~m_ready;
    assign w_redir   = e_valid & e_redirect;
    assign w_rs1_hit = d_use_rs1 & (d_rs1 == e_rd);
    assign w_rs2_hit = d_use_rs2 & (d_rs2 == e_rd);
    assign w_lu      = d_valid & e_valid & e_is_load & (e_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
    assign w_fwait   = ~i_ready | (r_fstate == FS_DISCARD);

    // Fetch-state register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (!nrst) r_fstate <= FS_RUN;
        else       r_fstate <= w_fstate_nxt;
    end

    // Priority-encoded stall/flush outputs and fetch next-state logic.
    always_comb begin
        stall_pc     = 1'b0;
        stall_fd     = 1'b0;
        stall_de     = 1'b0;
        stall_em     = 1'b0;
        flush_fd     = 1'b0;
        flush_de     = 1'b0;
        w_fstate_nxt = r_fstate;

        if (nrst) begin
            if (w_dstall) begin
                stall_pc = 1'b1;
                stall_fd = 1'b1;
                stall_de = 1'b1;
                stall_em = 1'b1;
            end else if (w_redir) begin
                flush_fd = 1'b1;
                flush_de = 1'b1;
            end else if (w_lu) begin
                stall_pc = 1'b1;
                stall_fd = 1'b1;
                flush_de = 1'b1;
            end else if (w_fwait) begin
                stall_pc = 1'b1;
                flush_fd = 1'b1;
            end
        end

        // The stale word arrives even while MEM is stalled, so DISCARD may
        // always retire; entering DISCARD needs the redirect actually taken.
        case (r_fstate)
            FS_RUN: begin
                if (!w_dstall && w_redir && !i_ready) w_fstate_nxt = FS_DISCARD;
            end
            FS_DISCARD: begin
                if (i_ready) w_fstate_nxt = FS_RUN;
            end
            default: w_fstate_nxt = FS_RUN;
        endcase
    end

    // Watchdog: count consecutive dmem-stall cycles, latch a sticky timeout.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else if (w_dstall) begin
            if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == C_TIMEOUT_LAST) r_mem_timeout <= 1'b1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    assign mem_timeout = r_mem_timeout;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;
    logic        w_redir_flush;

    // Only redirect-caused D/E flushes count as flush events.
    assign w_redir_flush = nrst & ~w_dstall & w_redir;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (stall_pc)      r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_redir_flush) r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

`default_nettype wire
